mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  EX/MEM pipeline register plus data-memory access controller; sits directly downstream of the Execute stage.
//  - Captures ALU result, store data, destination register and control bits from Execute.
//  - Runs each load/store over a req/ack data-memory bus with variable latency.
//  - Stalls the pipeline until the access completes, then hands the result to the MEM/WB register.
//  - ALUOutM is also the forwarding source fed back to the Execute stage.
// PARAMETERS
//  WIDTH   32  datapath width (address, store data, load data)
//  REG_AW  5   destination register index width
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  ALUOutE      in   WIDTH   ALU result / memory address from Execute
//  WriteDataE   in   WIDTH   store data from Execute (already forwarded)
//  WriteRegE    in   REG_AW  destination register from Execute
//  RegWriteE    in   1       register write enable
//  MemtoRegE    in   1       instruction is a load
//  MemWriteE    in   1       instruction is a store
//  ALUOutM      out  WIDTH   registered ALU result (forwarding source, memory address)
//  WriteRegM    out  REG_AW  registered destination register
//  RegWriteM    out  1       registered register write enable (see CONFIGURATION)
//  MemtoRegM    out  1       registered load flag
//  ReadDataM    out  WIDTH   load data, registered on ack
//  StallM       out  1       high: hold the entire pipeline, including this stage
//  DmReq        out  1       data-memory request
//  DmWe         out  1       data-memory write enable (qualifies DmReq)
//  DmAddr       out  WIDTH   data-memory address (= ALUOutM)
//  DmWdata      out  WIDTH   data-memory store data
//  DmAck        in   1       data-memory completion; may be high in the same cycle as DmReq
//  DmRdata      in   WIDTH   load data, valid when DmAck is high
//  MisalignM    out  1       misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): all M registers, ReadDataM and WriteDataM are 0, FSM = IDLE. DmReq, StallM and MisalignM drop in the same cycle.
//  - EX/MEM register: on each clk edge with StallM=0, capture the E inputs. With StallM=1, hold.
//  - memopM = MemWriteM | MemtoRegM. If both are set, the access is a store (DmWe=1).
//  - FSM states IDLE, WAIT, DONE:
//    - IDLE: if memopM and DmAck -> DONE; if memopM and !DmAck -> WAIT; else stay in IDLE.
//    - WAIT: DmAck -> DONE; else stay in WAIT.
//    - DONE: -> IDLE unconditionally. A new memop captured at this edge issues its request in the next cycle.
//  - DmReq = memopM & (state != DONE). It is combinational and held until DmAck.
//  - DmAddr, DmWdata and DmWe remain stable while DmReq is high.
//  - StallM = memopM & (state != DONE). Minimum load/store cost is 1 stall cycle (zero-wait memory); N wait cycles give N+1 stall cycles.
//  - ReadDataM loads DmRdata on the IDLE/WAIT->DONE transition, for loads only, and holds otherwise. Stores leave ReadDataM unchanged.
//  - DmAck with DmReq low is ignored.
//  - Non-memory instructions: StallM=0 and no request; the instruction passes in one cycle.
//  - Back-to-back memops: DONE->IDLE, then the next request is issued. There is no overlap; at most one outstanding access.
//  - Reset mid-access: the request is abandoned and a late DmAck after reset is ignored. The memory must tolerate a dropped request.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined:
//    - A memop with ALUOutM[1:0] != 0 raises no DmReq; IDLE goes directly to DONE (1 stall cycle).
//    - MisalignM=1 during that DONE cycle. RegWriteM is forced to 0 for that instruction, and ReadDataM is unchanged.
//  MISALIGN_CHECK_EN undefined:
//    - Address bits are passed through unchecked and MisalignM is tied to 0.
// TESTING
//  1. Zero-wait load:
//     - Stimulus: MemtoRegE=1, ALUOutE=0x10, memory acks with DmAck=1 and DmRdata=0xCAFEF00D in the request cycle.
//     - Required: StallM high for exactly 1 cycle; ReadDataM=0xCAFEF00D in DONE; WriteRegM held for 2 cycles.
//  2. 3-wait store:
//     - Stimulus: MemWriteE=1, WriteDataE=0x12345678, ALUOutE=0x20, DmAck on the 4th request cycle.
//     - Required: DmReq=1, DmWe=1, DmAddr=0x20 and DmWdata=0x12345678 stable for 4 cycles; StallM high for 4 cycles.
//  3. ALU op:
//     - Stimulus: RegWriteE=1, ALUOutE=0x7, no memop.
//     - Required: no DmReq, StallM=0, ALUOutM=0x7 one cycle later.
//  4. Back-to-back loads to 0x0 and 0x4, zero-wait:
//     - Required: two distinct requests separated by a DONE cycle; ReadDataM takes each value in turn.
//  5. Async reset asserted in WAIT:
//     - Required: DmReq, StallM and RegWriteM go to 0 immediately; FSM=IDLE; a DmAck after reset does not change ReadDataM.
//  6. MISALIGN_CHECK_EN, load at 0x13:
//     - Required: no DmReq; MisalignM=1 for 1 cycle; RegWriteM=0; StallM high for 1 cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus: master is the MEM-stage controller, slave is the data memory.
interface mem_stage_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             DmReq;
  logic             DmWe;
  logic [WIDTH-1:0] DmAddr;
  logic [WIDTH-1:0] DmWdata;
  logic             DmAck;
  logic [WIDTH-1:0] DmRdata;

  modport master (
    output DmReq, DmWe, DmAddr, DmWdata,
    input  DmAck, DmRdata
  );

  modport slave (
    input  DmReq, DmWe, DmAddr, DmWdata,
    output DmAck, DmRdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// EX/MEM register plus data-memory req/ack controller; one access in flight, StallM holds the pipe until DmAck
// (min 1 stall cycle, N waits -> N+1). MISALIGN_CHECK_EN traps misaligned memops without issuing a request.
module mem_stage_ctrl #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  ALUOutE,
  input  logic [WIDTH-1:0]  WriteDataE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  output logic [WIDTH-1:0]  ALUOutM,
  output logic [REG_AW-1:0] WriteRegM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic [WIDTH-1:0]  ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  mem_stage_ctrl_if.master  dm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] writeDataM;
  logic             regWriteQ;
  logic             memWriteM;
  logic             memop;
  logic             isLoad;
  logic             misalign;
  logic             inAccess;
  logic             reqActive;
  logic             loadDone;

  // EX/MEM pipeline register; frozen for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUOutM    <= '0;
      writeDataM <= '0;
      WriteRegM  <= '0;
      regWriteQ  <= 1'b0;
      MemtoRegM  <= 1'b0;
      memWriteM  <= 1'b0;
    end else if (!StallM) begin
      ALUOutM    <= ALUOutE;
      writeDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
      regWriteQ  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      memWriteM  <= MemWriteE;
    end
  end

  assign memop  = memWriteM | MemtoRegM;
  // A load+store combination is treated as a store.
  assign isLoad = MemtoRegM & ~memWriteM;

`ifdef MISALIGN_CHECK_EN
  assign misalign = memop & (ALUOutM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    inAccess  = memop & (state != DONE);
    reqActive = inAccess & ~misalign;
    loadDone  = reqActive & dm.DmAck & isLoad;
    unique case (state)
      IDLE: begin
        if (memop) begin
          stateNext = (misalign || dm.DmAck) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dm.DmAck) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadDataM <= '0;
    end else if (loadDone) begin
      ReadDataM <= dm.DmRdata;
    end
  end

  assign StallM     = inAccess;
  assign dm.DmReq   = reqActive;
  assign dm.DmWe    = memWriteM;
  assign dm.DmAddr  = ALUOutM;
  assign dm.DmWdata = writeDataM;
  // A trapped access must not retire a register write.
  assign RegWriteM  = regWriteQ & ~misalign;
  assign MisalignM  = misalign & (state == DONE);

  aReqStable: assert property (@(posedge clk) disable iff (rst)
    (dm.DmReq && !dm.DmAck) |=> (dm.DmReq && $stable(dm.DmAddr) && $stable(dm.DmWe) && $stable(dm.DmWdata)));

  aDoneReleases: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |-> (!StallM && !dm.DmReq));

  aDoneOneCycle: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |=> (state == IDLE));

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: randomized instruction stream, reference model of retirements and memory accesses.
module tb_mem_stage_ctrl;
  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw;
    logic        mtr;
    logic        mw;
    int          lat;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    logic        mtr;
    logic [31:0] rdata;
    logic        mis;
    logic        req;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          lat;
  } acc_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  ALUOutE;
  logic [WIDTH-1:0]  WriteDataE;
  logic [REG_AW-1:0] WriteRegE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic [WIDTH-1:0]  ALUOutM;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic [WIDTH-1:0]  ReadDataM;
  logic              StallM;
  logic              MisalignM;

  mem_stage_ctrl_if #(.WIDTH(WIDTH)) dm ();

  mem_stage_ctrl #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUOutE    (ALUOutE),
    .WriteDataE (WriteDataE),
    .WriteRegE  (WriteRegE),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .ALUOutM    (ALUOutM),
    .WriteRegM  (WriteRegM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .dm         (dm)
  );

  always #5 clk = ~clk;

  exp_t        expQ[$];
  acc_t        accQ[$];
  int          nCmp = 0;
  int          nBad = 0;
  logic [31:0] lastRead = 32'h0;
  bit          timedOut = 1'b0;

  // Memory contents seen by both the responder and the model.
  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (a == 32'h10) return 32'hCAFE_F00D;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0FF0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nCmp++;
    if (act !== expv) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                                input logic rw, input logic mtr, input logic mw, input int lat);
    instr_t r;
    r.alu = alu; r.wd = wd; r.wr = wr; r.rw = rw; r.mtr = mtr; r.mw = mw; r.lat = lat;
    return r;
  endfunction

  function automatic instr_t randInstr();
    instr_t r;
    int     k;
    k     = $urandom_range(9, 0);
    r.wd  = $urandom;
    r.wr  = 5'($urandom);
    r.rw  = 1'($urandom);
    r.mtr = (k >= 4 && k <= 6) || k == 9;
    r.mw  = (k >= 7);
    if (r.mtr || r.mw) begin
      r.alu = $urandom & 32'h0000_03FC;
      if ($urandom_range(4, 0) == 0) r.alu[1:0] = 2'($urandom_range(3, 1));
      r.lat = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(4, 0);
    end else begin
      r.alu = $urandom;
      r.lat = 0;
    end
    return r;
  endfunction

  function automatic exp_t bubbleExp();
    exp_t e;
    e.alu = '0; e.wr = '0; e.rw = 1'b0; e.mtr = 1'b0; e.rdata = '0;
    e.mis = 1'b0; e.req = 1'b0; e.stalls = 0;
    return e;
  endfunction

  // Drive one instruction, wait for it to be captured, and record what it must do.
  task automatic issue(input instr_t in);
    exp_t e;
    acc_t a;
    bit   memop;
    int   n;
    ALUOutE    = in.alu;
    WriteDataE = in.wd;
    WriteRegE  = in.wr;
    RegWriteE  = in.rw;
    MemtoRegE  = in.mtr;
    MemWriteE  = in.mw;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (StallM && n < 40);
    if (StallM) begin
      nCmp++;
      nBad++;
      $display("FAIL capture_timeout: StallM still 1 after %0d cycles, required 0", n);
      timedOut = 1'b1;
    end
    memop    = in.mtr | in.mw;
    e.mis    = MIS_EN && memop && (in.alu[1:0] != 2'b00);
    e.req    = memop && !e.mis;
    e.stalls = !memop ? 0 : (e.mis ? 1 : in.lat + 1);
    e.alu    = in.alu;
    e.wr     = in.wr;
    e.rw     = in.rw && !e.mis;
    e.mtr    = in.mtr;
    if (e.req && in.mtr && !in.mw) lastRead = memVal(in.alu);
    e.rdata  = lastRead;
    expQ.push_back(e);
    if (e.req) begin
      a.addr = in.alu; a.wdata = in.wd; a.we = in.mw; a.lat = in.lat;
      accQ.push_back(a);
    end
    @(posedge clk);
    #1;
  endtask

  // Data-memory responder: checks each request against the model and answers after the chosen latency.
  bit   busy    = 1'b0;
  bit   lateAck = 1'b0;
  acc_t cur;
  int   cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (busy) lateAck = 1'b1;
      busy      = 1'b0;
      dm.DmAck  = 1'b0;
    end else if (lateAck) begin
      lateAck    = 1'b0;
      dm.DmAck   = 1'b1;
      dm.DmRdata = 32'hBAD0_BAD0;
    end else if (dm.DmReq) begin
      if (!busy) begin
        if (accQ.size() == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL unexpected_req: DmReq=1 at addr 0x%08h, required no request", dm.DmAddr);
          cur.addr = dm.DmAddr; cur.wdata = dm.DmWdata; cur.we = dm.DmWe; cur.lat = 0;
        end else begin
          cur = accQ.pop_front();
          chk("DmAddr", dm.DmAddr, cur.addr);
          chk("DmWe", 32'(dm.DmWe), 32'(cur.we));
          if (cur.we) chk("DmWdata", dm.DmWdata, cur.wdata);
        end
        busy = 1'b1;
        cnt  = 0;
      end else begin
        chk("DmAddr_hold", dm.DmAddr, cur.addr);
        chk("DmWe_hold", 32'(dm.DmWe), 32'(cur.we));
        if (cur.we) chk("DmWdata_hold", dm.DmWdata, cur.wdata);
      end
      if (cnt >= cur.lat) begin
        dm.DmAck   = 1'b1;
        dm.DmRdata = cur.we ? $urandom : memVal(cur.addr);
        busy       = 1'b0;
      end else begin
        dm.DmAck   = 1'b0;
        dm.DmRdata = $urandom;
        cnt++;
      end
    end else begin
      dm.DmAck   = ($urandom_range(3, 0) == 0);
      dm.DmRdata = $urandom;
    end
  end

  // Monitor: every unstalled cycle retires the instruction held in M.
  int   stallCnt = 0;
  exp_t me;

  always @(negedge clk) begin
    if (rst) begin
      stallCnt = 0;
    end else if (expQ.size() > 0) begin
      me = expQ[0];
      if (StallM) begin
        stallCnt++;
        chk("DmReq_stalled", 32'(dm.DmReq), 32'(me.req));
      end else begin
        void'(expQ.pop_front());
        chk("ALUOutM", ALUOutM, me.alu);
        chk("WriteRegM", 32'(WriteRegM), 32'(me.wr));
        chk("RegWriteM", 32'(RegWriteM), 32'(me.rw));
        chk("MemtoRegM", 32'(MemtoRegM), 32'(me.mtr));
        chk("ReadDataM", ReadDataM, me.rdata);
        chk("MisalignM", 32'(MisalignM), 32'(me.mis));
        chk("stall_cycles", 32'(stallCnt), 32'(me.stalls));
        chk("DmReq_retire", 32'(dm.DmReq), 32'h0);
        stallCnt = 0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    ALUOutE    = '0;
    WriteDataE = '0;
    WriteRegE  = '0;
    RegWriteE  = 1'b0;
    MemtoRegE  = 1'b0;
    MemWriteE  = 1'b0;
    dm.DmAck   = 1'b0;
    dm.DmRdata = '0;
    expQ.push_back(bubbleExp());
    #12;
    chk("rst_StallM", 32'(StallM), 32'h0);
    chk("rst_DmReq", 32'(dm.DmReq), 32'h0);
    chk("rst_ALUOutM", ALUOutM, 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_RegWriteM", 32'(RegWriteM), 32'h0);
    chk("rst_MisalignM", 32'(MisalignM), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait load, 3-wait store, ALU op, back-to-back loads, load at 0x13.
    issue(mk(32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 0));
    issue(mk(32'h20, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 3));
    issue(mk(32'h7, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 0));
    issue(mk(32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 0));
    issue(mk(32'h4, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 0));
    issue(mk(32'h13, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1));
    issue(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0));

    for (int i = 0; i < 400 && !timedOut; i++) issue(randInstr());

    // Reset while the memory is still waiting to answer a load.
    issue(mk(32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 8));
    ALUOutE   = '0;
    RegWriteE = 1'b0;
    MemtoRegE = 1'b0;
    MemWriteE = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("wait_DmReq", 32'(dm.DmReq), 32'h1);
    chk("wait_StallM", 32'(StallM), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_DmReq", 32'(dm.DmReq), 32'h0);
    chk("arst_StallM", 32'(StallM), 32'h0);
    chk("arst_RegWriteM", 32'(RegWriteM), 32'h0);
    chk("arst_ReadDataM", ReadDataM, 32'h0);
    expQ.delete();
    accQ.delete();
    lastRead = 32'h0;
    expQ.push_back(bubbleExp());
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) issue(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0));

    for (int i = 0; i < 60 && !timedOut; i++) issue(randInstr());
    for (int i = 0; i < 3; i++) issue(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
